// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: bus widths, stack page, write kinds
// and FSM state encodings, plus small helpers for byte sequencing.
package store_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam logic [15:0] STACK_BASE = 16'h0100;

  typedef enum logic [1:0] {
    KIND_STORE    = 2'd0,
    KIND_PUSH1    = 2'd1,
    KIND_PUSH_PC  = 2'd2,
    KIND_PUSH_INT = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2,
    ST_WR2  = 2'd3
  } state_e;

  // Index of the final byte written for a given kind.
  function automatic logic [1:0] last_byte_idx(input kind_e k);
    logic [1:0] idx;
    case (k)
      KIND_PUSH_PC:  idx = 2'd1;
      KIND_PUSH_INT: idx = 2'd2;
      default:       idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] byte_idx(input state_e s);
    logic [1:0] idx;
    case (s)
      ST_WR1:  idx = 2'd1;
      ST_WR2:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_push(input kind_e k);
    return (k != KIND_STORE);
  endfunction

endpackage

// File: rtl/store_unit.sv
// Write-side memory sequencer: issues one byte write per phi1 cycle for
// register stores, single-byte pushes and multi-byte PC/interrupt pushes.
module store_unit #(
  parameter int REG_WIDTH  = store_unit_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = store_unit_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = store_unit_pkg::STACK_BASE
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            store_kind,
  input  logic [ADDR_WIDTH-1:0] eff_addr,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  sp,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_WIDTH-1:0]  data_out,
  output logic                  write_en,
  output logic [REG_WIDTH-1:0]  sp_next,
  output logic                  busy,
  output logic                  done
);
  import store_unit_pkg::*;

  localparam logic [REG_WIDTH-1:0] SP_ONE   = {{(REG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0] SP_RESET = {REG_WIDTH{1'b1}};

  state_e                r_state, w_state_next;
  kind_e                 r_kind, w_kind_sel;
  logic [ADDR_WIDTH-1:0] r_eff_addr, w_eff_sel;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_sel;
  logic [REG_WIDTH-1:0]  r_data, w_data_sel;
  logic [REG_WIDTH-1:0]  r_sp_work, w_sp_work_next;
  logic [REG_WIDTH-1:0]  r_sp_next, w_sp_next_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next, w_stack_addr;
  logic [REG_WIDTH-1:0]  r_data_out, w_data_out_next;
  logic                  r_write_en, w_write_en_next;
  logic                  r_done, w_done_next;
  logic                  r_busy;
  logic                  w_accept, w_push_active;

  // Operand selection: on the accept edge the next-cycle outputs come straight
  // from the inputs, otherwise from the latched working copy.
  always_comb begin
    w_accept      = (r_state == ST_IDLE) && start;
    w_push_active = (r_state != ST_IDLE) && is_push(r_kind);
    if (w_accept) begin
      w_kind_sel = kind_e'(store_kind);
      w_eff_sel  = eff_addr;
      w_pc_sel   = pc;
      w_data_sel = data_in;
    end else begin
      w_kind_sel = r_kind;
      w_eff_sel  = r_eff_addr;
      w_pc_sel   = r_pc;
      w_data_sel = r_data;
    end
  end

  // Next-state logic for the write sequencer.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_WR0;
        else          w_state_next = ST_IDLE;
      end
      ST_WR0: begin
        if (last_byte_idx(r_kind) == 2'd0) w_state_next = ST_IDLE;
        else                               w_state_next = ST_WR1;
      end
      ST_WR1: begin
        if (last_byte_idx(r_kind) == 2'd1) w_state_next = ST_IDLE;
        else                               w_state_next = ST_WR2;
      end
      ST_WR2:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Stack pointer bookkeeping: each completed push byte decrements (wrapping in page).
  always_comb begin
    if (w_accept) begin
      w_sp_work_next = sp;
    end else if (w_push_active) begin
      w_sp_work_next = r_sp_work - SP_ONE;
    end else begin
      w_sp_work_next = r_sp_work;
    end
    if (w_push_active) begin
      w_sp_next_next = r_sp_work - SP_ONE;
    end else begin
      w_sp_next_next = r_sp_next;
    end
    w_stack_addr = STACK_BASE + {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, w_sp_work_next};
  end

  // Bus outputs for the upcoming cycle; addr/data hold while idle.
  always_comb begin
    w_write_en_next = (w_state_next != ST_IDLE);
    w_done_next     = w_write_en_next &&
                      (byte_idx(w_state_next) == last_byte_idx(w_kind_sel));
    w_addr_next     = r_addr;
    w_data_out_next = r_data_out;
    if (w_write_en_next) begin
      case ({w_kind_sel, w_state_next})
        {KIND_STORE, ST_WR0}: begin
          w_addr_next     = w_eff_sel;
          w_data_out_next = w_data_sel;
        end
        {KIND_PUSH1, ST_WR0}: begin
          w_addr_next     = w_stack_addr;
          w_data_out_next = w_data_sel;
        end
        {KIND_PUSH_PC, ST_WR0}, {KIND_PUSH_INT, ST_WR0}: begin
          w_addr_next     = w_stack_addr;
          w_data_out_next = w_pc_sel[ADDR_WIDTH-1 -: REG_WIDTH];
        end
        {KIND_PUSH_PC, ST_WR1}, {KIND_PUSH_INT, ST_WR1}: begin
          w_addr_next     = w_stack_addr;
          w_data_out_next = w_pc_sel[REG_WIDTH-1:0];
        end
        {KIND_PUSH_INT, ST_WR2}: begin
          w_addr_next     = w_stack_addr;
          w_data_out_next = w_data_sel;
        end
        default: begin
          w_addr_next     = r_addr;
          w_data_out_next = r_data_out;
        end
      endcase
    end else begin
      w_addr_next     = r_addr;
      w_data_out_next = r_data_out;
    end
  end

  // State, working registers and registered bus outputs.
  always_ff @(posedge phi1) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_kind     <= KIND_STORE;
      r_eff_addr <= {ADDR_WIDTH{1'b0}};
      r_pc       <= {ADDR_WIDTH{1'b0}};
      r_data     <= {REG_WIDTH{1'b0}};
      r_sp_work  <= SP_RESET;
      r_sp_next  <= SP_RESET;
      r_addr     <= {ADDR_WIDTH{1'b0}};
      r_data_out <= {REG_WIDTH{1'b0}};
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_kind     <= w_kind_sel;
      r_eff_addr <= w_eff_sel;
      r_pc       <= w_pc_sel;
      r_data     <= w_data_sel;
      r_sp_work  <= w_sp_work_next;
      r_sp_next  <= w_sp_next_next;
      r_addr     <= w_addr_next;
      r_data_out <= w_data_out_next;
      r_write_en <= w_write_en_next;
      r_done     <= w_done_next;
      r_busy     <= (w_state_next != ST_IDLE);
    end
  end

  assign addr     = r_addr;
  assign data_out = r_data_out;
  assign write_en = r_write_en;
  assign sp_next  = r_sp_next;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
